// File: rtl/regfile_2r1w_sb_pkg.sv
// regfile_pkg
// Shared definitions for the two-read/one-write register file with a
// pending-write scoreboard: default geometry and the preset-restore sweep
// FSM state type.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweepState_e;

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// regfile_2r1w_sb_if
// Bundles every non-clock, non-reset signal of regfile_2r1w_sb.
//   RdAddrA/B, RdDataA/B, HazardA/B : two independent combinational read ports
//   WrAddr, WrData, RegWrite        : single write port
//   PendSet, PendAddr, PendVec      : pending-write scoreboard
//   ClearReq, Busy, ClearDone       : preset-restore sweep control
// master: the side that drives requests (CPU/testbench)
// slave : the register file itself
interface regfile_2r1w_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] RdAddrA;
    logic [ADDR_W-1:0] RdAddrB;
    logic [DATA_W-1:0] RdDataA;
    logic [DATA_W-1:0] RdDataB;
    logic              HazardA;
    logic              HazardB;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              RegWrite;
    logic              PendSet;
    logic [ADDR_W-1:0] PendAddr;
    logic [DEPTH-1:0]  PendVec;
    logic              ClearReq;
    logic              Busy;
    logic              ClearDone;

    modport master (
        output RdAddrA, RdAddrB, WrAddr, WrData, RegWrite, PendSet, PendAddr, ClearReq,
        input  RdDataA, RdDataB, HazardA, HazardB, PendVec, Busy, ClearDone
    );

    modport slave (
        input  RdAddrA, RdAddrB, WrAddr, WrData, RegWrite, PendSet, PendAddr, ClearReq,
        output RdDataA, RdDataB, HazardA, HazardB, PendVec, Busy, ClearDone
    );

endinterface

// File: rtl/regfile_2r1w_sb_scoreboard.sv
// regfile_scoreboard
// One pending bit per register. A register is marked pending by setEn_i and
// cleared by an accepted write or by the preset-restore sweep.
//   clk, Reset      : clock, asynchronous active-high reset (clears all bits)
//   setEn_i/Addr_i  : mark a register pending
//   clrEn_i/Addr_i  : accepted write retires a pending register
//   sweepClrEn_i/sweepIdx_i : sweep clears the register it is restoring
//   rdAddrA_i/B_i   : lookup addresses for the two read ports
//   pendVec_o       : full pending vector
//   pendA_o/pendB_o : pending bit of the addressed registers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    setEn_i,
    input  logic [ADDR_W-1:0]       setAddr_i,
    input  logic                    clrEn_i,
    input  logic [ADDR_W-1:0]       clrAddr_i,
    input  logic                    sweepClrEn_i,
    input  logic [ADDR_W-1:0]       sweepIdx_i,
    input  logic [ADDR_W-1:0]       rdAddrA_i,
    input  logic [ADDR_W-1:0]       rdAddrB_i,
    output logic [(1<<ADDR_W)-1:0]  pendVec_o,
    output logic                    pendA_o,
    output logic                    pendB_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Priority, lowest to highest: write clear, set, sweep clear.
    // A set in the same cycle as a write survives; the sweep overrides a set.
    always_comb begin
        pend_d = pend_q;
        if (clrEn_i) begin
            pend_d[clrAddr_i] = 1'b0;
        end
        if (setEn_i) begin
            pend_d[setAddr_i] = 1'b1;
        end
        if (sweepClrEn_i) begin
            pend_d[sweepIdx_i] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pendVec_o = pend_q;
    assign pendA_o   = pend_q[rdAddrA_i];
    assign pendB_o   = pend_q[rdAddrB_i];

endmodule

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb
// Register file with two combinational read ports, one synchronous write
// port, optional same-cycle write-to-read forwarding, a pending-write
// scoreboard and a sweep that restores every register to its preset value
// (register i holds i truncated to DATA_W).
//   clk   : rising-edge clock
//   Reset : asynchronous active-high reset; presets registers, clears
//           pending bits, aborts any sweep
//   bus   : regfile_2r1w_sb_if slave modport (read/write/scoreboard/sweep)
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             Reset,
    regfile_2r1w_sb_if.slave bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    sweepState_e       state_q;
    sweepState_e       state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    logic busy;
    logic clearDone;
    logic sweepWr;
    logic wrAccept;
    logic pendA;
    logic pendB;

    // Sweep FSM: one register restored per SWEEP cycle, index holds at the
    // last register rather than wrapping, then a single DONE cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy      = 1'b0;
        clearDone = 1'b0;
        sweepWr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ClearReq) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                busy    = 1'b1;
                sweepWr = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                clearDone = 1'b1;
                state_d   = IDLE;
                idx_d     = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign wrAccept = bus.RegWrite && !busy;

    // Sweep and user write never coincide because writes are refused while busy.
    always_comb begin
        regs_d = regs_q;
        if (sweepWr) begin
            regs_d[idx_q] = DATA_W'(idx_q);
        end else if (wrAccept) begin
            regs_d[bus.WrAddr] = bus.WrData;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .Reset        (Reset),
        .setEn_i      (bus.PendSet),
        .setAddr_i    (bus.PendAddr),
        .clrEn_i      (wrAccept),
        .clrAddr_i    (bus.WrAddr),
        .sweepClrEn_i (sweepWr),
        .sweepIdx_i   (idx_q),
        .rdAddrA_i    (bus.RdAddrA),
        .rdAddrB_i    (bus.RdAddrB),
        .pendVec_o    (bus.PendVec),
        .pendA_o      (pendA),
        .pendB_o      (pendB)
    );

    // A forwarded read already carries the incoming value, so it is not a hazard.
    always_comb begin
        bus.RdDataA = regs_q[bus.RdAddrA];
        bus.HazardA = pendA;
        if ((BYPASS != 0) && wrAccept && (bus.WrAddr == bus.RdAddrA)) begin
            bus.RdDataA = bus.WrData;
            bus.HazardA = 1'b0;
        end
    end

    always_comb begin
        bus.RdDataB = regs_q[bus.RdAddrB];
        bus.HazardB = pendB;
        if ((BYPASS != 0) && wrAccept && (bus.WrAddr == bus.RdAddrB)) begin
            bus.RdDataB = bus.WrData;
            bus.HazardB = 1'b0;
        end
    end

    assign bus.Busy      = busy;
    assign bus.ClearDone = clearDone;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb
// Self-checking bench for regfile_2r1w_sb: a forwarding instance, a
// non-forwarding instance sharing the same stimulus, and a DATA_W=4 /
// ADDR_W=5 instance for the wide-address sweep.
module tb_regfile_2r1w_sb;

    typedef struct {
        string       tag;
        logic [63:0] value;
    } expEntry_t;

    logic clk   = 1'b0;
    logic Reset = 1'b1;

    int checks = 0;
    int errors = 0;
    expEntry_t expQ [$];

    regfile_2r1w_sb_if #(.DATA_W(8), .ADDR_W(3)) busA ();
    regfile_2r1w_sb_if #(.DATA_W(8), .ADDR_W(3)) busNb ();
    regfile_2r1w_sb_if #(.DATA_W(4), .ADDR_W(5)) busW ();

    regfile_2r1w_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (busA)
    );

    regfile_2r1w_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) dutNb (
        .clk   (clk),
        .Reset (Reset),
        .bus   (busNb)
    );

    regfile_2r1w_sb #(.DATA_W(4), .ADDR_W(5), .BYPASS(1)) dutW (
        .clk   (clk),
        .Reset (Reset),
        .bus   (busW)
    );

    // The non-forwarding instance sees exactly the same requests.
    assign busNb.RdAddrA  = busA.RdAddrA;
    assign busNb.RdAddrB  = busA.RdAddrB;
    assign busNb.WrAddr   = busA.WrAddr;
    assign busNb.WrData   = busA.WrData;
    assign busNb.RegWrite = busA.RegWrite;
    assign busNb.PendSet  = busA.PendSet;
    assign busNb.PendAddr = busA.PendAddr;
    assign busNb.ClearReq = busA.ClearReq;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic expectVal(input string tag, input logic [63:0] value);
        expEntry_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input logic [63:0] observed);
        expEntry_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard-empty: observed %0h required an expected entry", observed);
        end else begin
            e = expQ.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] value);
        expectVal(tag, value);
        checkOutput(observed);
    endtask

    // Drives one cycle of requests after the falling edge, leaving time to settle.
    task automatic applyStimulus(input int rdA, input int rdB, input int wrAddr, input int wrData,
                                 input int regWrite, input int pendSet, input int pendAddr,
                                 input int clearReq);
        @(negedge clk);
        busA.RdAddrA  = 3'(rdA);
        busA.RdAddrB  = 3'(rdB);
        busA.WrAddr   = 3'(wrAddr);
        busA.WrData   = 8'(wrData);
        busA.RegWrite = 1'(regWrite);
        busA.PendSet  = 1'(pendSet);
        busA.PendAddr = 3'(pendAddr);
        busA.ClearReq = 1'(clearReq);
        #1;
    endtask

    initial begin
        int busyCnt;
        bit doneSeen;

        busA.RdAddrA  = '0;
        busA.RdAddrB  = '0;
        busA.WrAddr   = '0;
        busA.WrData   = '0;
        busA.RegWrite = 1'b0;
        busA.PendSet  = 1'b0;
        busA.PendAddr = '0;
        busA.ClearReq = 1'b0;
        busW.RdAddrA  = '0;
        busW.RdAddrB  = '0;
        busW.WrAddr   = '0;
        busW.WrData   = '0;
        busW.RegWrite = 1'b0;
        busW.PendSet  = 1'b0;
        busW.PendAddr = '0;
        busW.ClearReq = 1'b0;

        // Reset state
        #2;
        checkVal("reset Busy", busA.Busy, 0);
        checkVal("reset ClearDone", busA.ClearDone, 0);
        checkVal("reset HazardA", busA.HazardA, 0);
        checkVal("reset HazardB", busA.HazardB, 0);
        checkVal("reset PendVec", busA.PendVec, 0);
        @(negedge clk);
        Reset = 1'b0;

        // Preset values on both ports
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, 7 - i, 0, 0, 0, 0, 0, 0);
            checkVal("preset RdDataA", busA.RdDataA, 64'(i));
            checkVal("preset RdDataB", busA.RdDataB, 64'(7 - i));
        end
        checkVal("preset PendVec", busA.PendVec, 0);
        busW.RdAddrA = 5'd20;
        #1;
        checkVal("wide preset r20", busW.RdDataA, 4);

        // Forwarding versus non-forwarding write
        applyStimulus(3, 3, 3, 8'hA5, 1, 0, 0, 0);
        checkVal("bypass RdDataA same cycle", busA.RdDataA, 8'hA5);
        checkVal("nobypass RdDataA same cycle", busNb.RdDataA, 8'h03);
        applyStimulus(3, 3, 0, 0, 0, 0, 0, 0);
        checkVal("bypass RdDataA next cycle", busA.RdDataA, 8'hA5);
        checkVal("nobypass RdDataA next cycle", busNb.RdDataA, 8'hA5);

        // Scoreboard: set, hold two cycles, retire by write
        applyStimulus(5, 0, 0, 0, 0, 1, 5, 0);
        checkVal("hazard before set", busA.HazardA, 0);
        applyStimulus(5, 0, 0, 0, 0, 0, 0, 0);
        checkVal("hazard cycle 1", busA.HazardA, 1);
        applyStimulus(5, 0, 0, 0, 0, 0, 0, 0);
        checkVal("hazard cycle 2", busA.HazardA, 1);
        applyStimulus(5, 0, 5, 8'h11, 1, 0, 0, 0);
        checkVal("bypass write hazard", busA.HazardA, 0);
        checkVal("bypass write data", busA.RdDataA, 8'h11);
        checkVal("nobypass write hazard", busNb.HazardA, 1);
        checkVal("nobypass write data", busNb.RdDataA, 8'h05);
        applyStimulus(5, 0, 0, 0, 0, 0, 0, 0);
        checkVal("hazard after write", busA.HazardA, 0);
        checkVal("PendVec after write", busA.PendVec, 0);
        checkVal("RdDataA after write", busA.RdDataA, 8'h11);

        // Set and write to the same register in one cycle: set wins
        applyStimulus(5, 5, 5, 8'h22, 1, 1, 5, 0);
        checkVal("set+write hazardB", busA.HazardB, 0);
        applyStimulus(5, 5, 0, 0, 0, 0, 0, 0);
        checkVal("set+write PendVec", busA.PendVec, 8'h20);
        checkVal("set+write hazardA", busA.HazardA, 1);
        checkVal("set+write data", busA.RdDataA, 8'h22);

        // Fill with 0xFF, then sweep
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, i, 8'hFF, 1, 0, 0, 0);
        end
        applyStimulus(3, 6, 0, 0, 0, 0, 0, 1);
        checkVal("fill r3", busA.RdDataA, 8'hFF);
        checkVal("fill r6", busA.RdDataB, 8'hFF);
        checkVal("Busy at ClearReq", busA.Busy, 0);
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(0, 0, 0, 8'h77, 1, (k == 9) ? 1 : 0, 2, 0);
            checkVal("sweep Busy", busA.Busy, 1);
            checkVal("sweep ClearDone", busA.ClearDone, (k == 9) ? 1 : 0);
            if (k >= 2) begin
                checkVal("sweep write ignored", busA.RdDataA, 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("post sweep Busy", busA.Busy, 0);
        checkVal("post sweep ClearDone", busA.ClearDone, 0);
        checkVal("post sweep PendVec", busA.PendVec, 8'h04);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, 7 - i, 0, 0, 0, 0, 0, 0);
            checkVal("post sweep RdDataA", busA.RdDataA, 64'(i));
            checkVal("post sweep RdDataB", busA.RdDataB, 64'(7 - i));
        end

        // Reset in the middle of a sweep
        applyStimulus(6, 6, 6, 8'hFF, 1, 0, 0, 0);
        applyStimulus(6, 6, 0, 0, 0, 0, 0, 1);
        for (int s = 1; s <= 3; s++) begin
            applyStimulus(6, 6, 0, 0, 0, 0, 0, 0);
            checkVal("abort sweep Busy", busA.Busy, 1);
        end
        checkVal("abort r6 before reset", busA.RdDataA, 8'hFF);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        checkVal("abort Busy", busA.Busy, 0);
        checkVal("abort ClearDone", busA.ClearDone, 0);
        checkVal("abort r6 preset", busA.RdDataA, 6);
        checkVal("abort PendVec", busA.PendVec, 0);
        @(negedge clk);
        Reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(6, 6, 0, 0, 0, 0, 0, 0);
            checkVal("abort no ClearDone", busA.ClearDone, 0);
        end

        // Wide instance: 32-register sweep
        @(negedge clk);
        busW.RdAddrA  = 5'd20;
        busW.WrAddr   = 5'd20;
        busW.WrData   = 4'hF;
        busW.RegWrite = 1'b1;
        @(negedge clk);
        busW.RegWrite = 1'b0;
        busW.ClearReq = 1'b1;
        #1;
        checkVal("wide r20 written", busW.RdDataA, 4'hF);
        @(negedge clk);
        busW.ClearReq = 1'b0;
        busyCnt  = 0;
        doneSeen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (busW.ClearDone) begin
                doneSeen = 1'b1;
                break;
            end
            if (busW.Busy) begin
                busyCnt++;
            end
            @(negedge clk);
        end
        checkVal("wide ClearDone seen", doneSeen, 1);
        checkVal("wide sweep cycles", busyCnt, 32);
        @(negedge clk);
        #1;
        checkVal("wide Busy after", busW.Busy, 0);
        checkVal("wide r20 restored", busW.RdDataA, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sb.md
REGFILE_2R1W_SB -- requirements
Module: regfile_2r1w_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width in bits (1..64).
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding enabled, 0 = disabled.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports RdAddrA, RdAddrB  input  ADDR_W  read port A/B register number.
REQ-007 SHALL have ports RdDataA, RdDataB  output  DATA_W  read port A/B data, combinational.
REQ-008 SHALL have ports HazardA, HazardB  output  1  addressed register has a pending write.
REQ-009 SHALL have port WrAddr  input  ADDR_W  write register number.
REQ-010 SHALL have port WrData  input  DATA_W  write data.
REQ-011 SHALL have port RegWrite  input  1  write enable, sampled at posedge clk.
REQ-012 SHALL have ports PendSet  input  1, PendAddr  input  ADDR_W  mark register PendAddr pending.
REQ-013 SHALL have port PendVec  output  DEPTH  pending bit per register.
REQ-014 SHALL have port ClearReq  input  1  start preset-restore sweep.
REQ-015 SHALL have port Busy  output  1  sweep in progress.
REQ-016 SHALL have port ClearDone  output  1  one-cycle pulse at sweep completion.

Function
REQ-017 Write: RegWrite=1 and Busy=0 at posedge SHALL store WrData into reg[WrAddr]; write latency one cycle.
REQ-018 Reads SHALL return reg[RdAddrX] combinationally; both ports independent, same address allowed.
REQ-019 BYPASS=1: accepted write with WrAddr==RdAddrX SHALL drive WrData on RdDataX in the same cycle and force HazardX=0.
REQ-020 BYPASS=0: reads SHALL return the pre-write value until the edge commits.
REQ-021 Preset value of reg[i] SHALL be i truncated to DATA_W bits.
REQ-022 Scoreboard: PendSet=1 SHALL set PendVec[PendAddr] at posedge; accepted write SHALL clear PendVec[WrAddr].
REQ-023 PendSet and accepted write to the same address in one cycle: set SHALL win (bit ends 1).
REQ-024 HazardX SHALL equal PendVec[RdAddrX] except as in REQ-019.
REQ-025 FSM states IDLE, SWEEP, DONE; IDLE->SWEEP on ClearReq=1; SWEEP->DONE after index DEPTH-1 written; DONE->IDLE unconditionally next cycle.
REQ-026 SWEEP SHALL write preset value to reg[idx] and clear PendVec[idx], idx 0..DEPTH-1 one per cycle; sweep occupies exactly DEPTH cycles.
REQ-027 Busy SHALL be 1 in SWEEP and DONE; ClearDone SHALL be 1 only in DONE.
REQ-028 While Busy=1: RegWrite and ClearReq SHALL be ignored; PendSet SHALL still apply but swept index clear wins for the same address.
REQ-029 Sweep index counter SHALL be ADDR_W bits and SHALL not wrap past DEPTH-1.

Reset
REQ-030 Reset=1 SHALL asynchronously load all registers with preset values, clear PendVec, set FSM to IDLE, index 0.
REQ-031 After reset: Busy=0, ClearDone=0, HazardA=HazardB=0.
REQ-032 Reset mid-sweep SHALL abort the sweep with no ClearDone pulse.

Structure
REQ-033 Package regfile_pkg SHALL hold the FSM state typedef and default DATA_W/ADDR_W constants.
REQ-034 Scoreboard SHALL be sub-module regfile_scoreboard (PendVec set/clear, hazard lookup), parametrised by ADDR_W.

Verification
REQ-035 Reset, read all 8 addresses on A and B -> RdData equals address 0..7, PendVec=0.
REQ-036 Write 0xA5 to r3 with RdAddrA=3, BYPASS=1 -> RdDataA=0xA5 same cycle; BYPASS=0 -> 0x03 that cycle, 0xA5 next.
REQ-037 PendSet r5, then RegWrite r5=0x11 two cycles later -> HazardA(RdAddrA=5)=1 for two cycles, then 0; PendSet+write r5 same cycle -> PendVec[5]=1.
REQ-038 Write 0xFF to all regs, ClearReq -> Busy=1 for 9 cycles, ClearDone pulse in cycle 9, regs read 0..7, RegWrite during sweep ignored.
REQ-039 ClearReq, assert Reset in sweep cycle 4 -> all regs preset, Busy=0 immediately, no ClearDone.
REQ-040 DATA_W=4, ADDR_W=5 -> reg[20] presets to 4, sweep lasts 32 cycles.
